// File: rtl/vcache_stat_trigger.sv
// vcache_stat_trigger
// Watches accepted stores at the vcache input for the reserved print-stat
// address, queues their data as stat tags, waits a drain window so in-flight
// responses can retire, then broadcasts a one-cycle print_stat pulse with the
// tag. Also owns the free-running global cycle counter used by the profilers.
module vcache_stat_trigger #(
    parameter int                      addr_width_p   = 28,
    parameter int                      data_width_p   = 32,
    parameter logic [addr_width_p-1:0] print_addr_p   = 28'h0FFF_FF0,
    parameter int                      els_p          = 2,
    parameter int                      drain_cycles_p = 4,
    parameter int                      gap_cycles_p   = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         en_i,
    input  logic                         cache_v_i,
    input  logic                         cache_ready_i,
    input  logic                         cache_st_i,
    input  logic [addr_width_p-1:0]      cache_addr_i,
    input  logic [data_width_p-1:0]      cache_data_i,
    output logic [31:0]                  global_ctr_o,
    output logic                         print_stat_v_o,
    output logic [data_width_p-1:0]      print_stat_tag_o,
    output logic [$clog2(els_p+1)-1:0]   pending_o,
    output logic [7:0]                   drop_count_o
);

    localparam int ptr_w_lp     = $clog2(els_p);
    localparam int cnt_w_lp     = $clog2(els_p + 1);
    localparam int timer_max_lp = (drain_cycles_p > gap_cycles_p) ? drain_cycles_p : gap_cycles_p;
    localparam int timer_w_lp   = (timer_max_lp < 2) ? 1 : $clog2(timer_max_lp + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIRE  = 2'd2,
        GAP   = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [timer_w_lp-1:0]    timer_q, timer_d;

    logic [31:0]              global_ctr_q;
    logic [data_width_p-1:0]  tag_q;
    logic [data_width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0]      wptr_q, rptr_q;
    logic [cnt_w_lp-1:0]      count_q;
    logic [7:0]               drop_q;

    logic                     trigger;
    logic                     full;
    logic                     pop;
    logic                     push_ok;
    logic                     dropped;

    assign trigger = cache_v_i & cache_ready_i & cache_st_i & (cache_addr_i == print_addr_p);
    assign full    = (count_q == cnt_w_lp'(els_p));
    assign pop     = (state_q == FIRE);
    assign push_ok = trigger & (~full | pop);
    assign dropped = trigger & full & ~pop;

    // Free-running cycle counter, gated by the global enable, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            global_ctr_q <= '0;
        end else if (en_i) begin
            global_ctr_q <= global_ctr_q + 32'd1;
        end
    end

    // Pending-tag FIFO plus saturating drop counter; a pop frees room for a same-cycle push.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= cache_data_i;
                wptr_q        <= wptr_q + ptr_w_lp'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + ptr_w_lp'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + cnt_w_lp'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - cnt_w_lp'(1);
            end
            if (dropped && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // State register; the tag register captures the FIFO head on entry to FIRE.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (state_d == FIRE) begin
                tag_q <= mem_q[rptr_q];
            end
        end
    end

    // Next-state logic: wait for a queued tag, drain, fire once, then enforce the idle gap.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (drain_cycles_p == 0) begin
                        state_d = FIRE;
                    end else begin
                        state_d = DRAIN;
                        timer_d = timer_w_lp'(drain_cycles_p);
                    end
                end
            end
            DRAIN: begin
                if (timer_q == timer_w_lp'(1)) begin
                    state_d = FIRE;
                end else begin
                    timer_d = timer_q - timer_w_lp'(1);
                end
            end
            FIRE: begin
                if (gap_cycles_p == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    timer_d = timer_w_lp'(gap_cycles_p);
                end
            end
            GAP: begin
                if (timer_q == timer_w_lp'(1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - timer_w_lp'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign global_ctr_o     = global_ctr_q;
    assign print_stat_v_o   = (state_q == FIRE);
    assign print_stat_tag_o = tag_q;
    assign pending_o        = count_q;
    assign drop_count_o     = drop_q;

endmodule

// File: tb/tb_vcache_stat_trigger.sv
// Testbench for vcache_stat_trigger with default parameters.
// Expected pulses (tag and cycle) are queued when a trigger is driven and
// checked by a monitor whenever the DUT raises print_stat_v_o.
module tb_vcache_stat_trigger;

    localparam logic [27:0] PA    = 28'h0FFF_FF0;
    localparam int          DRAIN = 4;
    localparam int          GAP   = 2;

    typedef struct {
        logic [31:0] tag;
        int          cyc;
    } expect_t;

    logic        clk;
    logic        resetN;
    logic        en;
    logic        cacheV;
    logic        cacheReady;
    logic        cacheSt;
    logic [27:0] cacheAddr;
    logic [31:0] cacheData;
    logic [31:0] globalCtr;
    logic        printV;
    logic [31:0] printTag;
    logic [1:0]  pending;
    logic [7:0]  dropCount;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    logic        prevV   = 1'b0;
    expect_t     sb[$];

    vcache_stat_trigger #(
        .addr_width_p  (28),
        .data_width_p  (32),
        .print_addr_p  (PA),
        .els_p         (2),
        .drain_cycles_p(DRAIN),
        .gap_cycles_p  (GAP)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (resetN),
        .en_i            (en),
        .cache_v_i       (cacheV),
        .cache_ready_i   (cacheReady),
        .cache_st_i      (cacheSt),
        .cache_addr_i    (cacheAddr),
        .cache_data_i    (cacheData),
        .global_ctr_o    (globalCtr),
        .print_stat_v_o  (printV),
        .print_stat_tag_o(printTag),
        .pending_o       (pending),
        .drop_count_o    (dropCount)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: cycle k begins at the k-th rising edge
    always @(posedge clk) cyc++;

    // Pulse monitor: every pulse must match the scoreboard head, and never repeat back-to-back
    always @(negedge clk) begin
        if (printV) begin
            expect_t e;
            vectors++;
            assert (prevV === 1'b0) else begin
                errors++;
                $error("[TB] FAIL pulse_consecutive observed=1 expected=0 at cycle %0d", cyc);
            end
            vectors++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("[TB] FAIL pulse_unexpected observed tag=%h expected no pulse at cycle %0d", printTag, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                assert (printTag === e.tag) else begin
                    errors++;
                    $error("[TB] FAIL pulse_tag observed=%h expected=%h", printTag, e.tag);
                end
                vectors++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("[TB] FAIL pulse_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
            end
        end
        prevV = printV;
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Drive one request for one cycle; if a pulse is expected, queue its tag and cycle
    task automatic applyStimulus(input logic v, input logic rdy, input logic st,
                                 input logic [27:0] addr, input logic [31:0] data,
                                 input bit expFire, input int fireOffset);
        expect_t e;
        cacheV     = v;
        cacheReady = rdy;
        cacheSt    = st;
        cacheAddr  = addr;
        cacheData  = data;
        if (expFire) begin
            e.tag = data;
            e.cyc = cyc + fireOffset;
            sb.push_back(e);
        end
        @(negedge clk);
        cacheV     = 1'b0;
        cacheReady = 1'b0;
        cacheSt    = 1'b0;
        cacheAddr  = '0;
        cacheData  = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        resetN     = 1'b0;
        en         = 1'b1;
        cacheV     = 1'b0;
        cacheReady = 1'b0;
        cacheSt    = 1'b0;
        cacheAddr  = '0;
        cacheData  = '0;

        // Reset for three cycles with the enable high; counter must stay at zero
        tick(3);
        checkOutput("reset_ctr", globalCtr, 32'd0);
        checkOutput("reset_v", {31'd0, printV}, 32'd0);
        checkOutput("reset_tag", printTag, 32'd0);
        checkOutput("reset_pending", {30'd0, pending}, 32'd0);
        checkOutput("reset_drop", {24'd0, dropCount}, 32'd0);

        // Count ten enabled cycles, then hold with enable low
        resetN = 1'b1;
        tick(10);
        checkOutput("ctr_after_10", globalCtr, 32'd10);
        en = 1'b0;
        tick(3);
        checkOutput("ctr_hold", globalCtr, 32'd10);
        en = 1'b1;

        // Single trigger: pulse 2+DRAIN cycles later, pending spans through the fire cycle
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'h5, 1'b1, 2 + DRAIN);
        for (int i = 1; i <= 2 + DRAIN; i++) begin
            checkOutput($sformatf("single_pending_%0d", i), {30'd0, pending}, 32'd1);
            tick(1);
        end
        checkOutput("single_pending_after", {30'd0, pending}, 32'd0);
        tick(4);
        checkOutput("single_tag_held", printTag, 32'h5);

        // Non-triggers: unaccepted store, load, neighbouring address
        applyStimulus(1'b1, 1'b0, 1'b1, PA, 32'h11, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, PA, 32'h22, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, PA + 28'd1, 32'h33, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("ignore_pending_%0d", i), {30'd0, pending}, 32'd0);
            tick(1);
        end

        // Two back-to-back triggers: second fires GAP+2+DRAIN after the first
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'hA, 1'b1, 2 + DRAIN);
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'hB, 1'b1, 2 + DRAIN + GAP + 2 + DRAIN - 1);
        checkOutput("b2b_pending", {30'd0, pending}, 32'd2);
        tick(20);
        checkOutput("b2b_drained", {30'd0, pending}, 32'd0);
        checkOutput("b2b_last_tag", printTag, 32'hB);

        // Four triggers into a two-deep FIFO: two drops; then a push in the FIRE cycle is accepted
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'h1, 1'b1, 2 + DRAIN);
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'h2, 1'b1, 2 + DRAIN + GAP + 2 + DRAIN - 1);
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'h3, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'h4, 1'b0, 0);
        checkOutput("full_drop", {24'd0, dropCount}, 32'd2);
        checkOutput("full_pending", {30'd0, pending}, 32'd2);
        tick(2);
        checkOutput("fire_cycle_v", {31'd0, printV}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'h5A, 1'b1, 2 * (GAP + 2 + DRAIN));
        checkOutput("fire_push_drop", {24'd0, dropCount}, 32'd2);
        checkOutput("fire_push_pending", {30'd0, pending}, 32'd2);
        tick(22);
        checkOutput("full_drained", {30'd0, pending}, 32'd0);
        checkOutput("full_last_tag", printTag, 32'h5A);

        // Reset during DRAIN discards the queued tag and restarts the counter
        applyStimulus(1'b1, 1'b1, 1'b1, PA, 32'h77, 1'b0, 0);
        tick(2);
        resetN = 1'b0;
        tick(1);
        resetN = 1'b1;
        checkOutput("mid_reset_pending", {30'd0, pending}, 32'd0);
        checkOutput("mid_reset_ctr", globalCtr, 32'd0);
        checkOutput("mid_reset_drop", {24'd0, dropCount}, 32'd0);
        checkOutput("mid_reset_tag", printTag, 32'd0);
        tick(15);
        checkOutput("post_reset_ctr", globalCtr, 32'd15);
        checkOutput("post_reset_pending", {30'd0, pending}, 32'd0);

        // Counter wrap from all ones
        dut.global_ctr_q = 32'hFFFF_FFFF;
        #1;
        checkOutput("wrap_preload", globalCtr, 32'hFFFF_FFFF);
        tick(1);
        checkOutput("wrap_zero", globalCtr, 32'd0);

        tick(2);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
